mc_ctrl_fsm: RTL

Multicycle main control FSM with wait-state and multi-cycle-unit support. It sequences fetch, decode, execute, memory and writeback for the multicycle datapath. Unlike the single-cycle-memory controller it replaces, it handshakes with memory through `MemReq`/`mem_ready` and with a multi-cycle MUL/FPU unit through `McStart`/`mc_done`. An undefined opcode enters a sticky `FAULT` state. The block sits between the instruction register/decoder and the datapath control muxes.

---
 rtl/mc_ctrl_pkg.sv | 24 ++
 rtl/mc_ctrl_fsm_mem_wait_timer.sv | 22 ++
 rtl/mc_ctrl_fsm.sv | 101 ++++++++++
 3 files changed

// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: state encoding and datapath select constants for mc_ctrl_fsm
package mc_ctrl_pkg;
  typedef logic [3:0] state_t;
  localparam state_t S_FETCH    = 4'd0;
  localparam state_t S_DECODE   = 4'd1;
  localparam state_t S_MEMADR   = 4'd2;
  localparam state_t S_MEMRD    = 4'd3;
  localparam state_t S_MEMWB    = 4'd4;
  localparam state_t S_MEMWR    = 4'd5;
  localparam state_t S_EXECUTER = 4'd6;
  localparam state_t S_EXECUTEI = 4'd7;
  localparam state_t S_ALUWB    = 4'd8;
  localparam state_t S_BRANCH   = 4'd9;
  localparam state_t S_MCEXEC   = 4'd10;
  localparam state_t S_MCWB     = 4'd11;
  localparam state_t S_FAULT    = 4'd15;
  localparam logic [1:0] SRCA_PC    = 2'b01;
  localparam logic [1:0] SRCA_OLDPC = 2'b10;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;
  localparam logic [1:0] RES_MC     = 2'b11;
endpackage

// File: rtl/mc_ctrl_fsm_mem_wait_timer.sv
// mem_wait_timer: counts consecutive not-ready cycles in a memory wait state and flags timeout
// Ports: clk, reset (sync, active-high); i_wait = FSM is in FETCH/MEMRD/MEMWR;
// i_ready = mem_ready; o_timeout = this is the MAX_MEM_WAIT-th cycle and memory is still not ready.
module mem_wait_timer #(
  parameter int MAX_MEM_WAIT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic i_wait,
  input  logic i_ready,
  output logic o_timeout
);
  localparam int W = $clog2(MAX_MEM_WAIT + 1);
  logic [W-1:0] r_cnt;
  logic         w_stall;
  assign w_stall   = i_wait && !i_ready;
  assign o_timeout = w_stall && r_cnt == W'(MAX_MEM_WAIT - 1);
  // A ready cycle always leaves the wait state, so clearing on anything but a stall
  // is the same as clearing on entry.
  always_ff @(posedge clk)
    r_cnt <= reset ? '0 : w_stall ? r_cnt + W'(1) : '0;
endmodule

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multicycle main control FSM with memory wait states and multi-cycle unit handshake
// Ports: clk, reset (sync, active-high); Op/Funct/IsMc/IsFpu from decoder; mem_ready, mc_done
// handshakes; datapath controls IRWrite..ResultSrc, MemReq, McStart, Fault; state_o debug.
// Macro MC_CTRL_MEM_TIMEOUT_EN enables the memory wait timeout (MAX_MEM_WAIT cycles) into FAULT.
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int MAX_MEM_WAIT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic       IsMc,
  input  logic       IsFpu,
  input  logic       mem_ready,
  input  logic       mc_done,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic       NextPC,
  output logic       RegW,
  output logic       MemW,
  output logic       FPUW,
  output logic       Branch,
  output logic       ALUOp,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       MemReq,
  output logic       McStart,
  output logic       Fault,
  output logic [3:0] state_o
);
  state_t r_state, w_next;
  logic   r_fpu, r_mc_first, w_timeout, w_unused;
  assign w_unused = ^{Funct[4:1], 8'(MAX_MEM_WAIT)};
`ifdef MC_CTRL_MEM_TIMEOUT_EN
  logic w_wait;
  assign w_wait = r_state inside {S_FETCH, S_MEMRD, S_MEMWR};
  mem_wait_timer #(.MAX_MEM_WAIT(MAX_MEM_WAIT)) u_timer (
    .clk       (clk),
    .reset     (reset),
    .i_wait    (w_wait),
    .i_ready   (mem_ready),
    .o_timeout (w_timeout)
  );
`else
  assign w_timeout = 1'b0;
`endif
  always_comb begin
    w_next = S_FETCH;
    case (r_state)
      S_FETCH:    w_next = w_timeout ? S_FAULT : mem_ready ? S_DECODE : S_FETCH;
      S_DECODE:   w_next = Op == 2'b01 ? S_MEMADR : Op == 2'b10 ? S_BRANCH : Op == 2'b11 ? S_FAULT :
                           IsMc ? S_MCEXEC : Funct[5] ? S_EXECUTEI : S_EXECUTER;
      S_EXECUTER,
      S_EXECUTEI: w_next = S_ALUWB;
      S_MEMADR:   w_next = Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:    w_next = w_timeout ? S_FAULT : mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:    w_next = w_timeout ? S_FAULT : mem_ready ? S_FETCH : S_MEMWR;
      S_MCEXEC:   w_next = mc_done ? S_MCWB : S_MCEXEC;
      S_FAULT:    w_next = S_FAULT;
      default:    w_next = S_FETCH;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_FETCH;
      r_fpu      <= 1'b0;
      r_mc_first <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_fpu      <= r_state == S_DECODE ? IsFpu : r_fpu;
      r_mc_first <= r_state == S_DECODE && Op == 2'b00 && IsMc;
    end
  end
  always_comb begin
    {IRWrite, AdrSrc, NextPC, RegW, MemW, FPUW, Branch, ALUOp, MemReq, McStart, Fault} = '0;
    {ALUSrcA, ALUSrcB, ResultSrc} = '0;
    case (r_state)
      S_FETCH: begin
        {MemReq, ALUSrcA, ALUSrcB, ResultSrc} = {1'b1, SRCA_PC, SRCB_FOUR, RES_ALU};
        {IRWrite, NextPC} = {2{mem_ready}};
      end
      S_DECODE:   {ALUSrcA, ALUSrcB, ResultSrc} = {SRCA_PC, SRCB_FOUR, RES_ALU};
      S_EXECUTER: ALUOp = 1'b1;
      S_EXECUTEI: {ALUSrcB, ALUOp} = {SRCB_IMM, 1'b1};
      S_MEMADR:   ALUSrcB = SRCB_IMM;
      S_MEMRD:    {MemReq, AdrSrc} = 2'b11;
      S_MEMWR:    {MemReq, AdrSrc, MemW} = 3'b111;
      S_MEMWB:    {RegW, ResultSrc} = {1'b1, RES_MEM};
      S_ALUWB:    RegW = 1'b1;
      S_MCEXEC:   McStart = r_mc_first;
      S_MCWB:     {ResultSrc, FPUW, RegW} = {RES_MC, r_fpu, ~r_fpu};
      S_BRANCH:   {Branch, ALUSrcA, ALUSrcB, ResultSrc} = {1'b1, SRCA_OLDPC, SRCB_IMM, RES_ALU};
      S_FAULT:    Fault = 1'b1;
      default:    ;
    endcase
  end
  assign state_o = r_state;
endmodule
